scandoubler: RTL and testbench
==============================

SCANDOUBLER -- requirements
Module: scandoubler

Interface
REQ-001 SHALL have parameter LINE_DEPTH, default 1024, meaning pixel entries per line buffer bank.
REQ-002 SHALL have port clk_sys  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ce_pix  input  1  input pixel strobe (source rate).
REQ-005 SHALL have port ce_pix_x2  input  1  output pixel strobe at 2x ce_pix rate; every ce_pix cycle also has ce_pix_x2.
REQ-006 SHALL have port bypass  input  1  1 = pass input through without line doubling.
REQ-007 SHALL have ports R_in, G_in, B_in  input  6 each  source colour.
REQ-008 SHALL have ports HSync, VSync  input  1 each  source syncs, positive polarity.
REQ-009 SHALL have ports R_out, G_out, B_out  output  6 each  doubled colour, feeds OSD R_in/G_in/B_in.
REQ-010 SHALL have ports HSync_out, VSync_out  output  1 each  doubled syncs, positive polarity, feed OSD HSync/VSync.

Function
REQ-011 Input side SHALL act only on ce_pix; 11-bit hcnt_in increments per ce_pix, saturating at 2047.
REQ-012 Rising edge of HSync (sampled on ce_pix vs previous ce_pix sample) SHALL: latch line_len <= hcnt_in, set hcnt_in <= 0, toggle write bank wbank, set hcnt_out <= 0.
REQ-013 On each ce_pix with hcnt_in < LINE_DEPTH, {R_in,G_in,B_in} SHALL be written to bank[wbank][hcnt_in]; writes at hcnt_in >= LINE_DEPTH SHALL be dropped.
REQ-014 hs_len SHALL count ce_pix while HSync high, latched on HSync falling edge (saturating at 2047).
REQ-015 Output side SHALL act only on ce_pix_x2; hcnt_out increments and wraps to 0 when hcnt_out == line_len-1, so each input line yields exactly two output lines.
REQ-016 Read address SHALL be bank[~wbank][hcnt_out]; addresses >= LINE_DEPTH SHALL read as 0.
REQ-017 RAM read SHALL be registered; R/G/B_out SHALL appear exactly 1 ce_pix_x2 after address; HSync_out SHALL be delayed equally to stay aligned.
REQ-018 HSync_out SHALL be high while hcnt_out < hs_len (half source pulse duration).
REQ-019 VSync_out SHALL take the value of VSync sampled at each input HSync rising edge (one-line delay matching buffer latency).
REQ-020 While line_len == 0, R/G/B_out, HSync_out SHALL be 0.
REQ-021 HSync rising edge coinciding with hcnt_out wrap SHALL take the REQ-012 reset (hcnt_out <= 0) with priority.
REQ-022 bypass = 1 SHALL drive all outputs from inputs registered once on clk_sys (latency 1 clk_sys); counters and writes SHALL keep running so toggling bypass needs no resync.
REQ-023 Line buffers SHALL be 2 x LINE_DEPTH x 18 bit, inferred as block RAM, no read-during-write check needed (banks disjoint).

Reset
REQ-024 reset SHALL clear hcnt_in, hcnt_out, line_len, hs_len, wbank, sync edge history and all output registers to 0 on the next clk_sys edge, regardless of strobes.
REQ-025 RAM contents SHALL NOT be reset; REQ-020 masks stale data until first HSync rising edge after reset.
REQ-026 Reset mid-line SHALL give outputs 0 until the second input HSync rising edge (first complete measured line).

Verification
REQ-027 Source line 800 pixels, HSync high 96 ce_pix, ramp R_in = hcnt[5:0] -> per input line two output lines of 800 ce_pix_x2, HSync_out high 96 ce_pix_x2, R_out ramp 0..63 repeating, one line late.
REQ-028 Line of 1100 pixels -> line_len = 1100, pixels 1024..1099 output as 0, no write to address wrap.
REQ-029 VSync high for lines 10..11 -> VSync_out high for output lines 22..25 (2 input-line-aligned periods, one line delay).
REQ-030 Assert reset at pixel 400 of a line -> all outputs 0 next clk_sys, remain 0 until second HSync rise, then correct doubling.
REQ-031 bypass = 1 with random RGB/syncs -> outputs equal inputs delayed 1 clk_sys; bypass back to 0 -> doubled output on next output line with no glitch beyond one line.
REQ-032 HSync rise forced at hcnt_out == line_len-1 -> hcnt_out = 0 next ce_pix_x2, no extra short line.

Source files
------------

// File: rtl/scandoubler.sv
// rtl/scandoubler.sv - line doubler: writes source lines into a ping-pong buffer, replays each twice at 2x pixel rate
module scandoubler #(
  parameter int LINE_DEPTH = 1024
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       ce_pix_x2,
  input  logic       bypass,
  input  logic [5:0] R_in,
  input  logic [5:0] G_in,
  input  logic [5:0] B_in,
  input  logic       HSync,
  input  logic       VSync,
  output logic [5:0] R_out,
  output logic [5:0] G_out,
  output logic [5:0] B_out,
  output logic       HSync_out,
  output logic       VSync_out
);

  localparam int          AW    = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
  localparam logic [11:0] DEPTH = 12'(LINE_DEPTH);
  localparam logic [10:0] CMAX  = 11'h7FF;

  // Two banks: one is being filled by the source while the other is replayed.
  logic [17:0] mem [2][LINE_DEPTH];

  logic [10:0] hcnt_in;
  logic [10:0] hcnt_out;
  logic [10:0] line_len;
  logic [10:0] hs_len;
  logic [10:0] hs_cnt;
  logic        wbank;
  logic        hs_prev;
  logic        seen_rise;
  logic        vs_line;

  logic        hs_rise;
  logic        wr_bank;
  logic [10:0] wr_addr;
  logic        rd_ok;
  logic        hs_active;

  // Edge detect, write target and read masking for the current cycle.
  always_comb begin
    hs_rise   = 1'b0;
    wr_bank   = wbank;
    wr_addr   = hcnt_in;
    rd_ok     = 1'b0;
    hs_active = 1'b0;
    hs_rise   = ce_pix & HSync & ~hs_prev;
    // The pixel on the sync edge is pixel 0 of the new line, in the new bank.
    if (hs_rise) begin
      wr_bank = ~wbank;
      wr_addr = 11'd0;
    end
    rd_ok     = (line_len != 11'd0) && ({1'b0, hcnt_out} < DEPTH);
    hs_active = (line_len != 11'd0) && (hcnt_out < hs_len);
  end

  // Source-side counters: pixel position, measured line length and sync width.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt_in   <= 11'd0;
      line_len  <= 11'd0;
      hs_len    <= 11'd0;
      hs_cnt    <= 11'd0;
      wbank     <= 1'b0;
      hs_prev   <= 1'b0;
      seen_rise <= 1'b0;
      vs_line   <= 1'b0;
    end else if (ce_pix) begin
      hs_prev <= HSync;
      if (hs_rise) begin
        // The first edge after reset closes a partial line, so keep the output blanked.
        line_len  <= seen_rise ? hcnt_in : 11'd0;
        seen_rise <= 1'b1;
        hcnt_in   <= 11'd1;
        wbank     <= ~wbank;
        vs_line   <= VSync;
      end else if (hcnt_in != CMAX) begin
        hcnt_in <= hcnt_in + 11'd1;
      end
      if (HSync) begin
        if (!hs_prev)
          hs_cnt <= 11'd1;
        else if (hs_cnt != CMAX)
          hs_cnt <= hs_cnt + 11'd1;
      end else begin
        hs_cnt <= 11'd0;
        if (hs_prev)
          hs_len <= hs_cnt;
      end
    end
  end

  // Line buffer write port; pixels beyond the buffer depth are dropped.
  always_ff @(posedge clk_sys) begin
    if (ce_pix && ({1'b0, wr_addr} < DEPTH))
      mem[wr_bank][wr_addr[AW-1:0]] <= {R_in, G_in, B_in};
  end

  // Replay position: wraps at the measured length, source sync edge restarts it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt_out <= 11'd0;
    end else if (hs_rise) begin
      hcnt_out <= 11'd0;
    end else if (ce_pix_x2) begin
      if ((line_len != 11'd0) && (hcnt_out == line_len - 11'd1))
        hcnt_out <= 11'd0;
      else if (hcnt_out != CMAX)
        hcnt_out <= hcnt_out + 11'd1;
    end
  end

  // Registered output: either the once-registered source or the buffer readout.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      R_out     <= 6'd0;
      G_out     <= 6'd0;
      B_out     <= 6'd0;
      HSync_out <= 1'b0;
      VSync_out <= 1'b0;
    end else if (bypass) begin
      R_out     <= R_in;
      G_out     <= G_in;
      B_out     <= B_in;
      HSync_out <= HSync;
      VSync_out <= VSync;
    end else if (ce_pix_x2) begin
      if (rd_ok)
        {R_out, G_out, B_out} <= mem[~wbank][hcnt_out[AW-1:0]];
      else
        {R_out, G_out, B_out} <= 18'd0;
      HSync_out <= hs_active;
      VSync_out <= vs_line;
    end
  end

endmodule

// File: tb/tb_scandoubler.sv
// tb/tb_scandoubler.sv - directed bench for scandoubler
module tb_scandoubler;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce_pix;
  logic       ce_pix_x2;
  logic       bypass;
  logic [5:0] R_in, G_in, B_in;
  logic       HSync, VSync;
  logic [5:0] R_out, G_out, B_out;
  logic       HSync_out, VSync_out;

  int checks = 0;
  int errors = 0;
  int prev_len = 0;
  int prev_id = 0;

  scandoubler #(.LINE_DEPTH(1024)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .ce_pix_x2 (ce_pix_x2),
    .bypass    (bypass),
    .R_in      (R_in),
    .G_in      (G_in),
    .B_in      (B_in),
    .HSync     (HSync),
    .VSync     (VSync),
    .R_out     (R_out),
    .G_out     (G_out),
    .B_out     (B_out),
    .HSync_out (HSync_out),
    .VSync_out (VSync_out)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [19:0] obs();
    return {R_out, G_out, B_out, HSync_out, VSync_out};
  endfunction

  task automatic check(input string tag, input int e, input logic [19:0] expv);
    logic [19:0] o;
    o = obs();
    checks++;
    assert (o === expv) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, o, expv);
    end
  endtask

  // Expected doubled pixel q of line prev_id (ramp R, line id on G, high bits on B).
  function automatic logic [19:0] exp_pix(input int q, input int id, input int vs);
    logic [10:0] qv;
    logic [17:0] rgb;
    qv  = 11'(q);
    rgb = (q < 1024) ? {qv[5:0], 6'(id), 1'b0, qv[10:6]} : 18'd0;
    return {rgb, (q < 96), 1'(vs)};
  endfunction

  // mode 0: output must be blank, 1: previous line doubled, 2: not checked.
  task automatic drive_line(input int len, input int id, input int vs, input int mode,
                            input int rst_at);
    logic [10:0] pv;
    int          e;
    int          q;
    bit          zmode;
    zmode = (mode == 0);
    for (int p = 0; p < len; p++) begin
      for (int h = 0; h < 2; h++) begin
        pv     = 11'(p);
        ce_pix = (h == 0);
        if (h == 0) begin
          R_in  = pv[5:0];
          G_in  = 6'(id);
          B_in  = {1'b0, pv[10:6]};
          HSync = (p < 96);
          VSync = 1'(vs);
        end
        reset = (p == rst_at) && (h == 0);
        @(posedge clk_sys);
        #1;
        e = 2 * p + h;
        if (reset) begin
          reset = 1'b0;
          zmode = 1'b1;
          check("reset_midline", e, 20'd0);
        end else if (e > 0 && mode != 2) begin
          if (zmode) begin
            check("blank", e, 20'd0);
          end else begin
            q = (e - 1) % prev_len;
            check($sformatf("line%0d", id), e, exp_pix(q, prev_id, vs));
          end
        end
      end
    end
    prev_len = len;
    prev_id  = id;
  endtask

  initial begin
    logic [19:0] expv;
    reset     = 1'b1;
    ce_pix    = 1'b0;
    ce_pix_x2 = 1'b1;
    bypass    = 1'b0;
    R_in = 6'd0; G_in = 6'd0; B_in = 6'd0;
    HSync = 1'b0; VSync = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_state", 0, 20'd0);
    reset = 1'b0;

    drive_line(800, 1, 0, 0, -1);
    drive_line(800, 2, 0, 1, -1);
    drive_line(800, 3, 0, 1, -1);
    drive_line(1100, 4, 0, 1, -1);
    drive_line(800, 5, 0, 1, -1);
    drive_line(801, 6, 0, 1, -1);
    drive_line(400, 7, 0, 1, -1);
    drive_line(300, 8, 0, 1, -1);
    drive_line(200, 9, 1, 1, -1);
    drive_line(200, 10, 0, 1, -1);
    drive_line(800, 11, 0, 1, 400);
    drive_line(800, 12, 0, 0, -1);
    drive_line(800, 13, 0, 1, -1);

    bypass = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ce_pix = (i % 2 == 0);
      R_in   = 6'($urandom);
      G_in   = 6'($urandom);
      B_in   = 6'($urandom);
      HSync  = (i < 22) ? 1'($urandom) : 1'b0;
      VSync  = 1'($urandom);
      expv   = {R_in, G_in, B_in, HSync, VSync};
      @(posedge clk_sys);
      #1;
      check("bypass", i, expv);
    end
    bypass = 1'b0;

    drive_line(800, 14, 0, 2, -1);
    drive_line(800, 15, 0, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
